// File: rtl/spin_cmd_spi_rx_if.sv
// spin_cmd_spi_rx_if: SPI link plus memory-controller handshake for the spin command receiver.
interface spin_cmd_spi_rx_if #(parameter int ERR_CNT_W = 5);
   logic                 sck, cs_n, mosi, miso, done, start_spin, busy;
   logic [2:0]           final1_sprite, final2_sprite, final3_sprite;
   logic [ERR_CNT_W-1:0] err_count;
   modport master (
      output sck, cs_n, mosi, done,
      input  miso, start_spin, busy, final1_sprite, final2_sprite, final3_sprite, err_count
   );
   modport slave (
      input  sck, cs_n, mosi, done,
      output miso, start_spin, busy, final1_sprite, final2_sprite, final3_sprite, err_count
   );
endinterface

// File: rtl/spin_cmd_spi_rx.sv
// spin_cmd_spi_rx: SPI mode-0 spin command receiver feeding the reel memory controller.
// Define SPIN_CMD_CHECKSUM_EN to reject spin frames whose checksum field mismatches.
module spin_cmd_spi_rx #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [3:0] OP_SPIN     = 4'hA,
   parameter logic [3:0] OP_NOP      = 4'h0,
   parameter logic [2:0] MAX_SPRITE  = 3'd6,
   parameter int         ERR_CNT_W   = 5
) (
   input logic              clk,
   input logic              reset,
   spin_cmd_spi_rx_if.slave bus
);
`ifdef SPIN_CMD_CHECKSUM_EN
   localparam bit CK_EN = 1'b1;
`else
   localparam bit CK_EN = 1'b0;
`endif
   typedef enum logic [1:0] {IDLE, SHIFT, CHECK, ISSUE} state_t;
   state_t                 state, nxt;
   logic [SYNC_STAGES-1:0] sck_s, cs_s, mosi_s;
   logic                   sck_d, cs_d, sck_q, cs_q, mosi_q;
   logic                   sck_rise, sck_fall, cs_rise, cs_fall;
   logic [15:0]            sr;
   logic [4:0]             cnt;
   logic [7:0]             tx;
   logic [1:0]             last_err, err;
   logic [2:0]             r1, r2, r3;
   logic                   is_spin, is_nop, fmt_bad, accept;
   assign sck_q    = sck_s[SYNC_STAGES-1];
   assign cs_q     = cs_s[SYNC_STAGES-1];
   assign mosi_q   = mosi_s[SYNC_STAGES-1];
   assign sck_rise = sck_q & ~sck_d;
   assign sck_fall = ~sck_q & sck_d;
   assign cs_rise  = cs_q & ~cs_d;
   assign cs_fall  = ~cs_q & cs_d;
   // Chains reset low, so a cs_n fall is only seen once cs_n has been observed high after reset.
   always_ff @(posedge clk)
      if (reset) {sck_s, cs_s, mosi_s, sck_d, cs_d} <= '0;
      else begin
         sck_s  <= {sck_s[SYNC_STAGES-2:0], bus.sck};
         cs_s   <= {cs_s[SYNC_STAGES-2:0], bus.cs_n};
         mosi_s <= {mosi_s[SYNC_STAGES-2:0], bus.mosi};
         sck_d  <= sck_q;
         cs_d   <= cs_q;
      end
   always_ff @(posedge clk)
      state <= reset ? IDLE : nxt;
   always_comb
      case (state)
         IDLE:    nxt = cs_fall ? SHIFT : IDLE;
         SHIFT:   nxt = cs_rise ? CHECK : SHIFT;
         CHECK:   nxt = accept ? ISSUE : IDLE;
         default: nxt = IDLE;
      endcase
   always_comb begin
      bus.start_spin = (state == ISSUE);
      bus.miso       = tx[7] & ~cs_q;
   end
   // A done pulse coinciding with CHECK counts as already applied to busy.
   always_comb begin
      r1      = sr[11:9];
      r2      = sr[8:6];
      r3      = sr[5:3];
      is_spin = (sr[15:12] == OP_SPIN);
      is_nop  = (sr[15:12] == OP_NOP);
      fmt_bad = (!is_spin && !is_nop) || r1 > MAX_SPRITE || r2 > MAX_SPRITE || r3 > MAX_SPRITE ||
                (CK_EN && is_spin && sr[2:0] != (r1 ^ r2 ^ r3));
      err     = (cnt != 5'd16) ? 2'd1 : fmt_bad ? 2'd2 : (is_spin && bus.busy && !bus.done) ? 2'd3 : 2'd0;
      accept  = is_spin && err == 2'd0;
   end
   always_ff @(posedge clk)
      if (reset) begin
         sr                <= '0;
         cnt               <= '0;
         tx                <= '0;
         last_err          <= '0;
         bus.busy          <= 1'b0;
         bus.err_count     <= '0;
         bus.final1_sprite <= '0;
         bus.final2_sprite <= '0;
         bus.final3_sprite <= '0;
      end else begin
         if (state == IDLE && cs_fall) cnt <= '0;
         if (state == SHIFT && sck_rise) begin
            sr  <= {sr[14:0], mosi_q};
            cnt <= (cnt == 5'd17) ? cnt : cnt + 5'd1;
         end
         tx       <= cs_fall ? {bus.busy, last_err, 5'(bus.err_count)} : sck_fall ? {tx[6:0], 1'b0} : tx;
         bus.busy <= (state == CHECK && accept) || (bus.busy && !bus.done);
         if (state == CHECK) begin
            last_err <= err;
            if (err != 2'd0 && !(&bus.err_count)) bus.err_count <= bus.err_count + ERR_CNT_W'(1);
            if (accept) {bus.final1_sprite, bus.final2_sprite, bus.final3_sprite} <= sr[11:3];
         end
      end
endmodule

// File: tb/tb_spin_cmd_spi_rx.sv
// tb_spin_cmd_spi_rx: directed frame table plus done/reset corner sequences for spin_cmd_spi_rx.
module tb_spin_cmd_spi_rx;
`ifdef SPIN_CMD_CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif
   localparam logic [8:0] S351 = 9'b011_101_001;
   localparam logic [8:0] S246 = 9'b010_100_110;
   typedef struct {
      logic [31:0] data;
      int          nbits;
      bit          pre_done;
      bit          done_chk;
      bit          rst_mid;
      bit          exp_start;
      logic [8:0]  exp_spr;
      bit          exp_busy;
      logic [4:0]  exp_errc;
      logic [7:0]  exp_miso;
   } vec_t;
   logic clk = 1'b0;
   logic reset;
   int   n_chk = 0;
   int   n_fail = 0;
   vec_t v[11];
   spin_cmd_spi_rx_if bus();
   spin_cmd_spi_rx dut (.clk(clk), .reset(reset), .bus(bus.slave));
   always #20 clk = ~clk;
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask
   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic frame(input vec_t t, output logic [7:0] rx, output int start_at);
      rx = '0;
      bus.cs_n = 1'b0;
      clks(4);
      for (int i = 0; i < t.nbits; i++) begin
         if (t.rst_mid && i == 8) begin
            reset = 1'b1;
            clks(2);
            reset = 1'b0;
         end
         bus.mosi = t.data[t.nbits-1-i];
         clks(4);
         if (i < 8) rx = {rx[6:0], bus.miso};
         bus.sck = 1'b1;
         clks(4);
         bus.sck = 1'b0;
      end
      clks(4);
      bus.cs_n = 1'b1;
      start_at = -1;
      for (int k = 1; k <= 8; k++) begin
         clks(1);
         if (bus.start_spin) start_at = (start_at == -1) ? k : 99;
         if (k == 3 && t.done_chk) bus.done = 1'b1;
         if (k == 4) bus.done = 1'b0;
      end
   endtask
   initial begin
      logic [7:0] rx;
      int         start_at;
      v[0]  = '{32'hA74F,  16, 1'b0, 1'b0, 1'b0, 1'b1, S351,  1'b1, 5'd0, 8'h00};
      v[1]  = '{32'hA74F,  16, 1'b0, 1'b0, 1'b0, 1'b0, S351,  1'b1, 5'd1, 8'h80};
      v[2]  = '{32'h0000,  16, 1'b0, 1'b0, 1'b0, 1'b0, S351,  1'b1, 5'd1, 8'hE1};
      v[3]  = '{32'hAE07,  16, 1'b1, 1'b0, 1'b0, 1'b0, S351,  1'b0, 5'd2, 8'h01};
      v[4]  = '{32'h0A74,  12, 1'b0, 1'b0, 1'b0, 1'b0, S351,  1'b0, 5'd3, 8'h42};
      v[5]  = '{32'h0A74F, 17, 1'b0, 1'b0, 1'b0, 1'b0, S351,  1'b0, 5'd4, 8'h23};
      v[6]  = '{32'hA74E,  16, 1'b0, 1'b0, 1'b0, !CK,  S351,  !CK,  CK ? 5'd5 : 5'd4, 8'h24};
      v[7]  = '{32'hA530,  16, 1'b1, 1'b0, 1'b0, 1'b1, S246,  1'b1, CK ? 5'd5 : 5'd4, CK ? 8'h45 : 8'h04};
      v[8]  = '{32'hA74F,  16, 1'b0, 1'b1, 1'b0, 1'b1, S351,  1'b1, CK ? 5'd5 : 5'd4, CK ? 8'h85 : 8'h84};
      v[9]  = '{32'hA74F,  16, 1'b0, 1'b0, 1'b1, 1'b0, 9'd0,  1'b0, 5'd0, CK ? 8'h85 : 8'h84};
      v[10] = '{32'hA74F,  16, 1'b0, 1'b0, 1'b0, 1'b1, S351,  1'b1, 5'd0, 8'h00};
      reset = 1'b1;
      bus.sck = 1'b0;
      bus.cs_n = 1'b1;
      bus.mosi = 1'b0;
      bus.done = 1'b0;
      clks(3);
      reset = 1'b0;
      clks(4);
      check("reset_start", 32'(bus.start_spin), 32'd0);
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_errc", 32'(bus.err_count), 32'd0);
      check("reset_spr", 32'({bus.final1_sprite, bus.final2_sprite, bus.final3_sprite}), 32'd0);
      check("reset_miso", 32'(bus.miso), 32'd0);
      for (int i = 0; i < 11; i++) begin
         if (v[i].pre_done) begin
            check($sformatf("v%0d_busy_before_done", i), 32'(bus.busy), 32'(v[i-1].exp_busy));
            bus.done = 1'b1;
            clks(1);
            bus.done = 1'b0;
            check($sformatf("v%0d_busy_after_done", i), 32'(bus.busy), 32'd0);
            clks(2);
         end
         frame(v[i], rx, start_at);
         check($sformatf("v%0d_start_cycle", i), 32'(start_at), v[i].exp_start ? 32'd4 : 32'hFFFF_FFFF);
         check($sformatf("v%0d_sprites", i), 32'({bus.final1_sprite, bus.final2_sprite, bus.final3_sprite}), 32'(v[i].exp_spr));
         check($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(v[i].exp_busy));
         check($sformatf("v%0d_err_count", i), 32'(bus.err_count), 32'(v[i].exp_errc));
         check($sformatf("v%0d_miso_byte", i), 32'(rx), 32'(v[i].exp_miso));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
